shift_add_mac: RTL and testbench

Sequential unsigned shift-and-add multiply-accumulate stage of the unary shift MAC datapath. It accepts an operand pair (a, b) over a valid/ready handshake. It loads a into a left-shifting multiplicand register and b into a right-shifting multiplier register, then adds the multiplicand into a running accumulator for each set multiplier LSB. It consumes one multiplier bit per cycle, pulses out_valid when the product has been folded in, and exposes the accumulator to the downstream requantisation/readout logic.

---
 rtl/shift_add_mac.sv | 100 ++++++++++
 tb/tb_shift_add_mac.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mac.sv
// shift_add_mac: sequential unsigned shift-and-add multiply-accumulate.
// One multiplier bit per RUN cycle; product folds into a persistent accumulator.
module shift_add_mac #(
    parameter int N          = 16,
    parameter int ACC_BITS   = 40,
    parameter int EARLY_EXIT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    input  logic                acc_clear,
    output logic                out_valid,
    output logic [ACC_BITS-1:0] acc,
    output logic                overflow,
    output logic                busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam int PAD = ACC_BITS + 1 - 2 * N;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   cnt;
    logic [ACC_BITS:0] sum;
    logic            last;

    // Extra top bit of the sum is the carry out of the accumulator MSB.
    assign sum = {1'b0, acc} + {{PAD{1'b0}}, mcand};

    // Final RUN cycle: all N bits consumed, or nothing left to add.
    assign last = (cnt == CNT_LAST) ||
                  ((EARLY_EXIT != 0) && ((mplier >> 1) == '0));

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (acc_clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                    if (in_valid) begin
                        mcand  <= {{N{1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= sum[ACC_BITS-1:0];
                        if (sum[ACC_BITS]) begin
                            overflow <= 1'b1;
                        end
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mac.sv
// tb_shift_add_mac: three parameterisations checked against a
// transaction-level model (product, run length, wrap/overflow).
module tb_shift_add_mac;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic        iv [3];
    logic        clr [3];
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic        rdy [3];
    logic        ov [3];
    logic        bz [3];
    logic        of [3];
    logic [39:0] acc0, acc1;
    logic [31:0] acc2;

    int errors = 0;
    int checks = 0;

    int              m_left [3];
    longint unsigned m_acc [3];
    longint unsigned m_prod [3];
    bit              m_ovf [3];

    always #5 clk = ~clk;

    shift_add_mac #(.N(16), .ACC_BITS(40), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .a(av[0]), .b(bv[0]), .acc_clear(clr[0]), .out_valid(ov[0]),
        .acc(acc0), .overflow(of[0]), .busy(bz[0]));

    shift_add_mac #(.N(16), .ACC_BITS(40), .EARLY_EXIT(0)) u_full (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .a(av[1]), .b(bv[1]), .acc_clear(clr[1]), .out_valid(ov[1]),
        .acc(acc1), .overflow(of[1]), .busy(bz[1]));

    shift_add_mac #(.N(16), .ACC_BITS(32), .EARLY_EXIT(1)) u_a32 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .a(av[2]), .b(bv[2]), .acc_clear(clr[2]), .out_valid(ov[2]),
        .acc(acc2), .overflow(of[2]), .busy(bz[2]));

    function automatic int acc_bits(input int i);
        return (i == 2) ? 32 : 40;
    endfunction

    function automatic longint unsigned get_acc(input int i);
        case (i)
            0: return {24'd0, acc0};
            1: return {24'd0, acc1};
            default: return {32'd0, acc2};
        endcase
    endfunction

    // Number of RUN cycles for multiplier b on instance i.
    function automatic int run_len(input int i, input logic [15:0] b);
        if (i == 1) return 16;
        for (int k = 15; k >= 0; k--) begin
            if (b[k]) return k + 1;
        end
        return 1;
    endfunction

    task automatic chk(input string nm, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: m_left counts remaining busy cycles (RUN + DONE).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_left[i] = 0;
                m_acc[i]  = 0;
                m_ovf[i]  = 0;
                m_prod[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_left[i] == 0) begin
                    if (clr[i]) begin
                        m_acc[i] = 0;
                        m_ovf[i] = 0;
                    end
                    if (iv[i]) begin
                        m_prod[i] = longint'(av[i]) * longint'(bv[i]);
                        m_left[i] = run_len(i, bv[i]) + 1;
                    end
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 1) begin
                        longint unsigned s;
                        s = m_acc[i] + m_prod[i];
                        if ((s >> acc_bits(i)) != 0) m_ovf[i] = 1;
                        m_acc[i] = s & ((64'd1 << acc_bits(i)) - 1);
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("in_ready%0d", i), rdy[i], m_left[i] == 0);
                chk($sformatf("busy%0d", i), bz[i], m_left[i] != 0);
                chk($sformatf("out_valid%0d", i), ov[i], m_left[i] == 1);
                if (m_left[i] <= 1) begin
                    chk($sformatf("acc%0d", i), get_acc(i), m_acc[i]);
                    chk($sformatf("overflow%0d", i), of[i], m_ovf[i]);
                end
            end
        end
    end

    // One operation; returns the number of busy cycles before out_valid.
    task automatic op(input int i, input logic [15:0] a_i,
                      input logic [15:0] b_i, input logic c, output int runs);
        int t;
        runs = 0;
        t = 0;
        @(negedge clk);
        while (!rdy[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        iv[i] = 1'b1;
        av[i] = a_i;
        bv[i] = b_i;
        clr[i] = c;
        @(negedge clk);
        iv[i] = 1'b0;
        clr[i] = 1'b0;
        t = 0;
        while (!ov[i] && t < 100) begin
            if (bz[i]) runs++;
            @(negedge clk);
            t++;
        end
        chk("op_done_seen", ov[i], 1);
        @(negedge clk);
    endtask

    initial begin
        int r;
        int t;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 0; clr[i] = 0; av[i] = 0; bv[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy[0], 1);
        chk("rst_busy", bz[0], 0);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_acc", acc0, 0);
        chk("rst_overflow", of[2], 0);
        reset_n = 1'b1;

        op(0, 16'd3, 16'd5, 1'b1, r);
        chk("t1_runs", r, 3);
        chk("t1_acc", acc0, 15);
        chk("t1_ovf", of[0], 0);
        chk("t1_ready_back", rdy[0], 1);

        op(0, 16'hFFFF, 16'hFFFF, 1'b0, r);
        chk("t2_runs", r, 16);
        chk("t2_acc", acc0, 40'hFFFE0010);

        op(0, 16'h1234, 16'h0000, 1'b0, r);
        chk("t3_runs_ee", r, 1);
        chk("t3_acc_ee", acc0, 40'hFFFE0010);
        op(1, 16'h1234, 16'h0000, 1'b1, r);
        chk("t3_runs_full", r, 16);
        chk("t3_acc_full", acc1, 0);
        op(1, 16'h0000, 16'h00FF, 1'b0, r);
        chk("t3_a0_runs", r, 16);
        chk("t3_a0_acc", acc1, 0);

        op(2, 16'hFFFF, 16'hFFFF, 1'b1, r);
        op(2, 16'hFFFF, 16'hFFFF, 1'b0, r);
        chk("t4_acc", acc2, 32'hFFFC0002);
        chk("t4_ovf", of[2], 1);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        chk("t4_clr_acc", acc2, 0);
        chk("t4_clr_ovf", of[2], 0);

        // Held in_valid and acc_clear across an operation.
        @(negedge clk);
        iv[0] = 1'b1; av[0] = 16'd3; bv[0] = 16'd5; clr[0] = 1'b0;
        @(negedge clk);
        av[0] = 16'd5; bv[0] = 16'd7; clr[0] = 1'b1;
        t = 0;
        while (!ov[0] && t < 100) begin
            chk("t5_ready_low", rdy[0], 0);
            @(negedge clk);
            t++;
        end
        chk("t5_no_clear", acc0, 40'hFFFE001F);
        @(negedge clk);
        chk("t5_idle_ready", rdy[0], 1);
        @(negedge clk);
        iv[0] = 1'b0; clr[0] = 1'b0;
        t = 0;
        while (!ov[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t5_acc_new", acc0, 35);
        @(negedge clk);

        // Reset in the middle of a long operation.
        iv[0] = 1'b1; av[0] = 16'd1; bv[0] = 16'h8000;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_busy_before", bz[0], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", rdy[0], 1);
        chk("t6_rst_acc", acc0, 0);
        chk("t6_rst_ovf", of[0], 0);
        chk("t6_rst_ov", ov[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        op(0, 16'd2, 16'd3, 1'b0, r);
        chk("t6_acc", acc0, 6);

        for (int n = 0; n < 60; n++) begin
            int i;
            logic [15:0] ra;
            logic [15:0] rb;
            logic rc;
            i = $urandom_range(0, 2);
            ra = 16'($urandom);
            rb = 16'($urandom & ((32'd1 << $urandom_range(0, 16)) - 1));
            rc = ($urandom_range(0, 7) == 0);
            op(i, ra, rb, rc, r);
            chk("rand_runs", r, run_len(i, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
